// File: rtl/vin_timing_detect.sv
// ============================================================================
// vin_timing_detect -- measures HDMI-in line/frame timing and locks onto it
// Revision: 1.0
// ============================================================================
`default_nettype none

module vin_timing_detect #(
  parameter int CW            = 12,
  parameter int STABLE_FRAMES = 3
) (
  input  logic          vin_clk_i,
  input  logic          rst_i,
  input  logic          vin_hs_i,
  input  logic          vin_vs_i,
  input  logic          vin_de_i,
  output logic [CW-1:0] h_active_o,
  output logic [CW-1:0] h_start_o,
  output logic [CW-1:0] h_total_o,
  output logic [CW-1:0] v_active_o,
  output logic [CW-1:0] v_total_o,
  output logic          locked_o,
  output logic          frame_o,
  output logic          lock_lost_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [3:0]    LOCK_AT = 4'(STABLE_FRAMES - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic hs_s_q, vs_s_q, de_s_q, hs_p_q, vs_p_q, de_p_q;
  logic hs_rise, vs_rise, de_rise;

  always_ff @(posedge vin_clk_i) begin
    if (rst_i) begin
      {hs_s_q, vs_s_q, de_s_q, hs_p_q, vs_p_q, de_p_q} <= '0;
    end else begin
      {hs_s_q, vs_s_q, de_s_q} <= {vin_hs_i, vin_vs_i, vin_de_i};
      {hs_p_q, vs_p_q, de_p_q} <= {hs_s_q, vs_s_q, de_s_q};
    end
  end

  assign hs_rise = hs_s_q & ~hs_p_q;
  assign vs_rise = vs_s_q & ~vs_p_q;
  assign de_rise = de_s_q & ~de_p_q;

  logic [CW-1:0]   h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, st_cnt_q, st_cnt_d;
  logic [CW-1:0]   v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d, v_inc, va_inc;
  logic [3*CW-1:0] ref_q, ref_d, ref_inc, line_tuple;
  logic [5*CW-1:0] cap_q, cap_d, cand_q, out_q;
  logic            ref_ok_q, ref_ok_d, bad_q, bad_d, bad_inc;
  logic            cap_bad_q, cap_bad_d, evt_q, evt_d, line_act, line_bad;

  // Tuple layout: {h_active, h_start, h_total}; a closing line on the VS-rise
  // cycle is folded into the "inc" values before the frame is captured.
  always_comb begin
    line_act   = (de_cnt_q != '0);
    line_tuple = {de_cnt_q, st_cnt_q, h_cnt_q};
    line_bad   = de_s_q | (h_cnt_q == CNT_MAX) |
                 (line_act & ((de_cnt_q == CNT_MAX) | (st_cnt_q == CNT_MAX)));
    h_cnt_d    = hs_rise ? CW'(1) : sat_inc(h_cnt_q);
    de_cnt_d   = hs_rise ? {{(CW-1){1'b0}}, de_s_q} :
                 (de_s_q ? sat_inc(de_cnt_q) : de_cnt_q);
    st_cnt_d   = de_rise ? CW'(1) : sat_inc(st_cnt_q);
    v_inc      = hs_rise ? sat_inc(v_cnt_q) : v_cnt_q;
    va_inc     = (hs_rise & line_act) ? sat_inc(va_cnt_q) : va_cnt_q;
    ref_inc    = (hs_rise & line_act & ~ref_ok_q) ? line_tuple : ref_q;
    bad_inc    = bad_q | (v_inc == CNT_MAX) | (va_inc == CNT_MAX) |
                 (hs_rise & (line_bad | (line_act & ref_ok_q & (line_tuple != ref_q))));
    v_cnt_d    = v_inc;
    va_cnt_d   = va_inc;
    ref_d      = ref_inc;
    ref_ok_d   = ref_ok_q | (hs_rise & line_act);
    bad_d      = bad_inc;
    cap_d      = cap_q;
    cap_bad_d  = cap_bad_q;
    evt_d      = 1'b0;
    if (vs_rise) begin
      cap_d     = {ref_inc, va_inc, v_inc};
      cap_bad_d = bad_inc | (va_inc == '0);
      evt_d     = 1'b1;
      v_cnt_d   = '0;
      va_cnt_d  = '0;
      ref_d     = '0;
      ref_ok_d  = 1'b0;
      bad_d     = 1'b0;
    end
  end

  always_ff @(posedge vin_clk_i) begin
    if (rst_i) begin
      {h_cnt_q, de_cnt_q, st_cnt_q, v_cnt_q, va_cnt_q} <= '0;
      {ref_q, ref_ok_q, bad_q, cap_q, cap_bad_q, evt_q} <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      de_cnt_q  <= de_cnt_d;
      st_cnt_q  <= st_cnt_d;
      v_cnt_q   <= v_cnt_d;
      va_cnt_q  <= va_cnt_d;
      ref_q     <= ref_d;
      ref_ok_q  <= ref_ok_d;
      bad_q     <= bad_d;
      cap_q     <= cap_d;
      cap_bad_q <= cap_bad_d;
      evt_q     <= evt_d;
    end
  end

  state_t     state_q;
  logic [3:0] stable_q;
  logic       cand_ok_q, locked_q, frame_q, lost_q, timeout;

  assign timeout = (h_cnt_q == CNT_MAX) | (v_cnt_q == CNT_MAX);

  // A candidate stored from an inconsistent frame is never counted as a match.
  always_ff @(posedge vin_clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      stable_q  <= '0;
      cand_q    <= '0;
      cand_ok_q <= 1'b0;
      out_q     <= '0;
      locked_q  <= 1'b0;
      frame_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      lost_q  <= 1'b0;
      if (timeout) begin
        state_q   <= ST_IDLE;
        locked_q  <= 1'b0;
        stable_q  <= '0;
        cand_ok_q <= 1'b0;
        lost_q    <= (state_q == ST_LOCKED);
      end else if (evt_q) begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_MEASURE;
            stable_q  <= '0;
            cand_ok_q <= 1'b0;
          end
          ST_MEASURE: begin
            if (cand_ok_q && !cap_bad_q && cap_q == cand_q) begin
              stable_q <= stable_q + 4'd1;
              if (stable_q == LOCK_AT) begin
                out_q    <= cap_q;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end
            end else begin
              cand_q    <= cap_q;
              cand_ok_q <= ~cap_bad_q;
              stable_q  <= '0;
            end
          end
          ST_LOCKED: begin
            if (!cap_bad_q && cap_q == out_q) begin
              frame_q <= 1'b1;
            end else begin
              state_q   <= ST_MEASURE;
              locked_q  <= 1'b0;
              lost_q    <= 1'b1;
              cand_q    <= cap_q;
              cand_ok_q <= ~cap_bad_q;
              stable_q  <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign {h_active_o, h_start_o, h_total_o, v_active_o, v_total_o} = out_q;
  assign locked_o    = locked_q;
  assign frame_o     = frame_q;
  assign lock_lost_o = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_vin_timing_detect.sv
// ============================================================================
// tb_vin_timing_detect -- table-driven frame bench for vin_timing_detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vin_timing_detect;

  localparam int CW = 12;

  logic          clk, rst, hs, vs, de;
  logic [CW-1:0] h_active, h_start, h_total, v_active, v_total;
  logic          locked, frame_p, lost_p;

  vin_timing_detect #(.CW(CW), .STABLE_FRAMES(3)) dut (
    .vin_clk_i  (clk),
    .rst_i      (rst),
    .vin_hs_i   (hs),
    .vin_vs_i   (vs),
    .vin_de_i   (de),
    .h_active_o (h_active),
    .h_start_o  (h_start),
    .h_total_o  (h_total),
    .v_active_o (v_active),
    .v_total_o  (v_total),
    .locked_o   (locked),
    .frame_o    (frame_p),
    .lock_lost_o(lost_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one 200-cycle frame; expectations are what the DUT shows on the
  // 4th cycle of that frame (the verdict on the previous frame) plus pulse
  // counts over the whole frame window.
  typedef struct {
    int n_act; bit bad; bit novs; int shift; int rst_at;
    bit lock; int ha; int hs; int ht; int va; int vt; int fr; int lost;
  } row_t;

  row_t rows[40];
  int   n_rows, n_pass, n_chk, n_fr, n_lost, exp_prev;
  logic s2_lock, s_lock, r_lock, r_outs;
  logic [CW-1:0] s_ha, s_hs, s_ht, s_va, s_vt;

  task automatic add(input int n_act, input bit bad, input bit novs, input int shift,
                     input int rst_at, input bit lock, input int va, input int fr,
                     input int lost, input bit zero_out);
    rows[n_rows] = '{n_act, bad, novs, shift, rst_at, lock,
                     zero_out ? 0 : 12, zero_out ? 0 : 16, zero_out ? 0 : 20,
                     zero_out ? 0 : va, zero_out ? 0 : 10, fr, lost};
    n_rows++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_frame(input int i);
    int p, ln, o, de_len;
    n_fr = 0;
    n_lost = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_p) n_fr++;
      if (lost_p) n_lost++;
      if (c == 2) s2_lock = locked;
      if (c == 3) begin
        s_lock = locked;
        s_ha = h_active; s_hs = h_start; s_ht = h_total; s_va = v_active; s_vt = v_total;
      end
      if (rows[i].rst_at >= 0 && c == rows[i].rst_at + 1) begin
        r_lock = locked;
        r_outs = |{h_active, h_start, h_total, v_active, v_total, frame_p, lost_p};
      end
      p      = c + rows[i].shift;
      ln     = (p / 20) % 10;
      o      = p % 20;
      de_len = (rows[i].bad && ln == 5) ? 11 : 12;
      vs     = !rows[i].novs && c < 20;
      hs     = (o == 16) || (o == 17);
      de     = (ln >= 10 - rows[i].n_act) && (o < de_len);
      rst    = (c == rows[i].rst_at);
    end
  endtask

  task automatic apply_row(input int i);
    run_frame(i);
    chk($sformatf("r%0d_latency_lock", i), s2_lock, exp_prev);
    chk($sformatf("r%0d_lock", i), s_lock, rows[i].lock);
    chk($sformatf("r%0d_h_active", i), s_ha, rows[i].ha);
    chk($sformatf("r%0d_h_start", i), s_hs, rows[i].hs);
    chk($sformatf("r%0d_h_total", i), s_ht, rows[i].ht);
    chk($sformatf("r%0d_v_active", i), s_va, rows[i].va);
    chk($sformatf("r%0d_v_total", i), s_vt, rows[i].vt);
    chk($sformatf("r%0d_frame_pulses", i), n_fr, rows[i].fr);
    chk($sformatf("r%0d_lost_pulses", i), n_lost, rows[i].lost);
    exp_prev = rows[i].lock;
    if (rows[i].rst_at >= 0) begin
      chk($sformatf("r%0d_rst_locked", i), r_lock, 0);
      chk($sformatf("r%0d_rst_outputs", i), r_outs, 0);
      exp_prev = 0;
    end
  endtask

  task automatic reset_and_check(input string name);
    @(negedge clk);
    {hs, vs, de} = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_locked"}, locked, 0);
    chk({name, "_outputs"}, {h_active, h_start, h_total, v_active, v_total}, 0);
    chk({name, "_pulses"}, {frame_p, lost_p}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    exp_prev = 0;
  endtask

  initial begin
    n_rows = 0; n_pass = 0; n_chk = 0; exp_prev = 0;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
    // Steady 6-line timing, then a 7-line change, then a DE=11 line.
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 1, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 1, 6, 1, 0, 0);
    add(7, 0, 0, 18, -1, 1, 6, 1, 0, 0);
    add(7, 0, 0, 18, -1, 0, 6, 0, 1, 0);
    add(7, 0, 0, 18, -1, 0, 6, 0, 0, 0);
    add(7, 0, 0, 18, -1, 1, 7, 0, 0, 0);
    add(7, 1, 0, 18, -1, 1, 7, 1, 0, 0);
    add(6, 0, 0, 18, -1, 0, 7, 0, 1, 0);
    add(6, 0, 0, 18, -1, 0, 7, 0, 0, 0);
    add(6, 0, 0, 18, -1, 0, 7, 0, 0, 0);
    add(6, 0, 0, 18, -1, 1, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 1, 6, 1, 0, 0);
    // After timeout: HS-only frame, relock, then a 1-cycle reset while locked.
    add(6, 0, 1, 18, -1, 0, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 0, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 0, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 0, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 1, 6, 0, 0, 0);
    add(6, 0, 0, 18, 100, 1, 6, 1, 0, 0);
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 18, -1, 1, 6, 0, 0, 0);
    add(6, 0, 0, 18, -1, 1, 6, 1, 0, 0);
    // HS and VS rising together every frame.
    add(6, 0, 0, 16, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 16, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 16, -1, 0, 0, 0, 0, 1);
    add(6, 0, 0, 16, -1, 1, 6, 0, 0, 0);
    add(6, 0, 0, 16, -1, 1, 6, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_locked", locked, 0);
    chk("reset_outputs", {h_active, h_start, h_total, v_active, v_total}, 0);
    chk("reset_pulses", {frame_p, lost_p}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 15; i++) apply_row(i);

    // HS and VS stop for longer than the counter range while locked.
    n_fr = 0;
    n_lost = 0;
    for (int c = 0; c < 4300; c++) begin
      @(negedge clk);
      if (frame_p) n_fr++;
      if (lost_p) n_lost++;
      {hs, vs, de} = 3'b000;
    end
    chk("timeout_lost_pulses", n_lost, 1);
    chk("timeout_locked", locked, 0);
    chk("timeout_frame_pulses", n_fr, 0);
    chk("timeout_hold_v_active", v_active, 6);
    exp_prev = 0;

    for (int i = 15; i < 26; i++) apply_row(i);
    reset_and_check("midreset");
    for (int i = 26; i < n_rows; i++) apply_row(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vin_timing_detect.md
VIN_TIMING_DETECT -- requirements
Module: vin_timing_detect

Interface
REQ-001 Parameter CW, default 12, width of all counters and measurement outputs.
REQ-002 Parameter STABLE_FRAMES, default 3, number of consecutive identical frames required to assert lock (legal range 2..15).
REQ-003 vin_clk_i  in  1  pixel clock; the block has one clock, and all logic is clocked on its rising edge.
REQ-004 rst_i  in  1  reset; it is synchronous and active-high.
REQ-005 vin_hs_i / vin_vs_i / vin_de_i  in  1 each  raw HDMI-in sync and data-enable signals, active-high.
REQ-006 h_active_o  out  CW  DE-high pixels per active line.
REQ-007 h_start_o  out  CW  cycles from DE rise to the following HS rise.
REQ-008 h_total_o  out  CW  cycles between consecutive HS rises.
REQ-009 v_active_o  out  CW  lines per frame containing at least one DE-high cycle.
REQ-010 v_total_o  out  CW  HS rises per frame.
REQ-011 locked_o  out  1  measurement outputs are valid and stable.
REQ-012 frame_o  out  1  one-cycle pulse at every frame boundary while locked.
REQ-013 lock_lost_o  out  1  one-cycle pulse on the LOCKED-to-unlocked transition.

Function
REQ-014 Input stage: the block SHALL register the three inputs once, then keep a second register of each for edge detection; a "rise" is registered=1 AND previous=0.
REQ-015 Line boundary: HS rise; frame boundary: VS rise.
REQ-016 Per line: count cycles since the last HS rise (h_total), DE-high cycles (h_active), and cycles from the latest DE rise to the HS rise (h_start).
REQ-017 Per frame: count HS rises (v_total) and lines with DE activity (v_active).
REQ-018 Frame consistency: every DE-active line in a frame SHALL have identical h_active, h_start and h_total; the first DE-active line sets the reference, and any differing line marks the frame inconsistent.
REQ-019 Every counter SHALL saturate at 2^CW-1; a saturated count SHALL mark the frame inconsistent.
REQ-020 FSM states: IDLE, MEASURE, LOCKED.
REQ-021 IDLE: ignore data until the first VS rise, then clear the frame accumulators and go to MEASURE (the partial first frame is discarded).
REQ-022 MEASURE, at each VS rise, the block SHALL compare the captured frame tuple with the previous candidate tuple.
REQ-023 MEASURE, equal and consistent: increment stable_cnt; when stable_cnt reaches STABLE_FRAMES-1, load the outputs from the tuple and go to LOCKED.
REQ-024 MEASURE, unequal or inconsistent: store the tuple as the new candidate, with stable_cnt=0.
REQ-025 LOCKED, at each VS rise with a tuple equal to the outputs and consistent: pulse frame_o and stay in LOCKED.
REQ-026 LOCKED, at a VS rise with a mismatch or inconsistency: go to MEASURE, deassert locked_o, pulse lock_lost_o, store the new candidate with stable_cnt=0, and hold the measurement outputs at their last locked values.
REQ-027 Timeout: a saturated h_total counter (no HS) or v_total counter (no VS) in any state SHALL force IDLE; if the state was LOCKED, lock_lost_o SHALL pulse.
REQ-028 Latency: outputs, locked_o and pulses SHALL update on the 3rd rising edge counting the edge that first samples vin_vs_i high as the 1st.
REQ-029 Simultaneous HS and VS rise: the block SHALL close the line first, include it in the frame, then close the frame.
REQ-030 HS rise while DE is high: the block SHALL treat this as a line boundary and mark the frame inconsistent.
REQ-031 A frame with v_active=0 SHALL be treated as inconsistent.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL set: state=IDLE, all counters and candidates=0, all outputs=0 including locked_o, frame_o and lock_lost_o.
REQ-033 Reset asserted mid-frame or while LOCKED SHALL drop locked_o on the next edge without pulsing lock_lost_o.
REQ-034 After reset is released, lock SHALL require a fresh IDLE start plus STABLE_FRAMES full frames.

Verification
REQ-035 Steady timing: h_total=20, DE 12 cycles at line offsets 0..11, HS rise at offset 16, v_total=10, 6 DE lines, STABLE_FRAMES=3 -> locked_o rises at the 4th VS rise after reset with outputs 12/16/20/6/10; frame_o pulses at each later VS rise.
REQ-036 Once locked, change one frame to 7 DE lines -> lock_lost_o pulses and locked_o falls at that VS rise, outputs hold 12/16/20/6/10; relock after 3 good frames, yielding 7 if the new timing persists.
REQ-037 One line in a frame with DE=11 cycles -> the frame is inconsistent and lock is not achieved or is lost; 3 subsequent clean frames relock.
REQ-038 Stop HS for 2^CW cycles while locked -> state IDLE, lock_lost_o pulses once, locked_o=0.
REQ-039 Assert rst_i for 1 cycle while locked -> all outputs 0 next edge, no lock_lost_o pulse, relock after 4 VS rises.
REQ-040 HS and VS rising in the same cycle every frame -> v_total includes that line, and lock is achieved normally.
